alu_rs: RTL

- Reservation station feeding the integer ALU: buffers dispatched ALU/branch micro-ops and snoops the ALU and LSU common data buses (CDBs) for operand wakeup.
- Each cycle it issues at most one ready entry to the ALU's rs_* input port.
- Sits between the dispatch stage and the ALU. It is the producer of the ALU's rs_* interface and a consumer of both CDBs.

---
 rtl/alu_rs.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs
// Description : ALU reservation station. Buffers dispatched micro-ops, snoops
//               the ALU and LSU CDBs for operand wakeup, issues one ready
//               entry per cycle. Optional macro ALU_RS_WAKE_ISSUE_EN allows
//               same-edge wakeup-and-issue with CDB forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_IDX_W = 4,
    parameter int OPT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rob_clr,
    input  logic                 dsp_valid,
    input  logic [OPT_W-1:0]     dsp_opt,
    input  logic [31:0]          dsp_v1,
    input  logic [31:0]          dsp_v2,
    input  logic [ROB_IDX_W-1:0] dsp_q1,
    input  logic [ROB_IDX_W-1:0] dsp_q2,
    input  logic [31:0]          dsp_imm,
    input  logic [ROB_IDX_W-1:0] dsp_rob_idx,
    output logic                 rs_full,
    input  logic                 cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_alu_src,
    input  logic [31:0]          cdb_alu_val,
    input  logic                 cdb_lsu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_lsu_src,
    input  logic [31:0]          cdb_lsu_val,
    output logic                 rs_valid,
    output logic [OPT_W-1:0]     rs_opt,
    output logic [31:0]          rs_val1,
    output logic [31:0]          rs_val2,
    output logic [31:0]          rs_imm,
    output logic [ROB_IDX_W-1:0] rs_rob_idx
);

    localparam int c_IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   r_busy;
    logic [OPT_W-1:0]     r_opt [RS_SIZE];
    logic [31:0]          r_v1  [RS_SIZE];
    logic [31:0]          r_v2  [RS_SIZE];
    logic [31:0]          r_imm [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_q1  [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_q2  [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_rob [RS_SIZE];

    logic [RS_SIZE-1:0]   w_hit1;
    logic [RS_SIZE-1:0]   w_hit2;
    logic [31:0]          w_wake_v1 [RS_SIZE];
    logic [31:0]          w_wake_v2 [RS_SIZE];
    logic [31:0]          w_op1     [RS_SIZE];
    logic [31:0]          w_op2     [RS_SIZE];
    logic [RS_SIZE-1:0]   w_ready;

    logic                 w_free_found;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic                 w_iss_found;
    logic [c_IDX_W-1:0]   w_iss_idx;

    logic [31:0]          w_dsp_v1;
    logic [31:0]          w_dsp_v2;
    logic [ROB_IDX_W-1:0] w_dsp_q1;
    logic [ROB_IDX_W-1:0] w_dsp_q2;

    assign rs_full = &r_busy;

    // Per-entry CDB tag match; ALU bus wins if both buses carry the same tag.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_hit1[i]    = 1'b0;
            w_hit2[i]    = 1'b0;
            w_wake_v1[i] = r_v1[i];
            w_wake_v2[i] = r_v2[i];
            if (r_q1[i] != '0) begin
                if (cdb_alu_valid && (r_q1[i] == cdb_alu_src)) begin
                    w_hit1[i]    = 1'b1;
                    w_wake_v1[i] = cdb_alu_val;
                end else if (cdb_lsu_valid && (r_q1[i] == cdb_lsu_src)) begin
                    w_hit1[i]    = 1'b1;
                    w_wake_v1[i] = cdb_lsu_val;
                end
            end
            if (r_q2[i] != '0) begin
                if (cdb_alu_valid && (r_q2[i] == cdb_alu_src)) begin
                    w_hit2[i]    = 1'b1;
                    w_wake_v2[i] = cdb_alu_val;
                end else if (cdb_lsu_valid && (r_q2[i] == cdb_lsu_src)) begin
                    w_hit2[i]    = 1'b1;
                    w_wake_v2[i] = cdb_lsu_val;
                end
            end
`ifdef ALU_RS_WAKE_ISSUE_EN
            w_op1[i]   = w_wake_v1[i];
            w_op2[i]   = w_wake_v2[i];
            w_ready[i] = r_busy[i] && ((r_q1[i] == '0) || w_hit1[i])
                                   && ((r_q2[i] == '0) || w_hit2[i]);
`else
            w_op1[i]   = r_v1[i];
            w_op2[i]   = r_v2[i];
            w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
`endif
        end
    end

    // Lowest-index free and ready entries (scan downwards so the last hit wins).
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_iss_found  = 1'b0;
        w_iss_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_iss_found = 1'b1;
                w_iss_idx   = c_IDX_W'(i);
            end
        end
    end

    // A tag broadcast in the dispatch cycle would otherwise never be seen again.
    always_comb begin
        w_dsp_v1 = dsp_v1;
        w_dsp_q1 = dsp_q1;
        w_dsp_v2 = dsp_v2;
        w_dsp_q2 = dsp_q2;
        if (dsp_q1 != '0) begin
            if (cdb_alu_valid && (dsp_q1 == cdb_alu_src)) begin
                w_dsp_v1 = cdb_alu_val;
                w_dsp_q1 = '0;
            end else if (cdb_lsu_valid && (dsp_q1 == cdb_lsu_src)) begin
                w_dsp_v1 = cdb_lsu_val;
                w_dsp_q1 = '0;
            end
        end
        if (dsp_q2 != '0) begin
            if (cdb_alu_valid && (dsp_q2 == cdb_alu_src)) begin
                w_dsp_v2 = cdb_alu_val;
                w_dsp_q2 = '0;
            end else if (cdb_lsu_valid && (dsp_q2 == cdb_lsu_src)) begin
                w_dsp_v2 = cdb_lsu_val;
                w_dsp_q2 = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            rs_valid   <= 1'b0;
            rs_opt     <= '0;
            rs_val1    <= '0;
            rs_val2    <= '0;
            rs_imm     <= '0;
            rs_rob_idx <= '0;
        end else if (rdy) begin
            if (rob_clr) begin
                r_busy   <= '0;
                rs_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && w_hit1[i]) begin
                        r_v1[i] <= w_wake_v1[i];
                        r_q1[i] <= '0;
                    end
                    if (r_busy[i] && w_hit2[i]) begin
                        r_v2[i] <= w_wake_v2[i];
                        r_q2[i] <= '0;
                    end
                end
                if (w_iss_found) begin
                    r_busy[w_iss_idx] <= 1'b0;
                    rs_valid          <= 1'b1;
                    rs_opt            <= r_opt[w_iss_idx];
                    rs_val1           <= w_op1[w_iss_idx];
                    rs_val2           <= w_op2[w_iss_idx];
                    rs_imm            <= r_imm[w_iss_idx];
                    rs_rob_idx        <= r_rob[w_iss_idx];
                end else begin
                    rs_valid <= 1'b0;
                end
                // The free slot is never the issuing one: that entry is still busy.
                if (dsp_valid && w_free_found) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_opt[w_free_idx]  <= dsp_opt;
                    r_v1[w_free_idx]   <= w_dsp_v1;
                    r_q1[w_free_idx]   <= w_dsp_q1;
                    r_v2[w_free_idx]   <= w_dsp_v2;
                    r_q2[w_free_idx]   <= w_dsp_q2;
                    r_imm[w_free_idx]  <= dsp_imm;
                    r_rob[w_free_idx]  <= dsp_rob_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire
